// File: rtl/serial_add_arbiter_if.sv
// Request/response bundle for serial_add_arbiter; req_sub/rsp_sub exist only
// when SERIAL_ADD_SUB_EN is defined.
interface serial_add_arbiter_if #(
   parameter int unsigned WIDTH = 8
);
   logic [1:0]         req_valid;
   logic [1:0]         req_ready;
   logic [2*WIDTH-1:0] req_a;
   logic [2*WIDTH-1:0] req_b;
   logic               rsp_valid;
   logic               rsp_ready;
   logic               rsp_id;
   logic [WIDTH-1:0]   rsp_sum;
   logic               rsp_carry;
`ifdef SERIAL_ADD_SUB_EN
   logic [1:0]         req_sub;
   logic               rsp_sub;
`endif

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
`ifdef SERIAL_ADD_SUB_EN
      input  req_sub,
      output rsp_sub,
`endif
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
`ifdef SERIAL_ADD_SUB_EN
      output req_sub,
      input  rsp_sub,
`endif
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
   );
endinterface

// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin front end sharing one LSB-first bit-serial adder.
// Define SERIAL_ADD_SUB_EN to add per-request subtraction (A-B, carry = no borrow).
module serial_add_arbiter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_add_arbiter_if.slave bus,
   output logic                busy
);
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d, carry_q, carry_d;
   logic             id_q, id_d, prio_q, prio_d;
   logic             grant;
   logic [1:0]       ready;
   logic             bit_sum, bit_carry;
   logic [WIDTH-1:0] op_a, op_b;
`ifdef SERIAL_ADD_SUB_EN
   logic             sub_q, sub_d;
`endif

   // Contention is resolved by prio; a lone requester always wins.
   always_comb begin
      grant = (bus.req_valid == 2'b11) ? prio_q : bus.req_valid[1];
      ready = '0;
      if (state_q == IDLE) ready[grant] = |bus.req_valid;
      op_a = grant ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
      op_b = grant ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
   end

   assign bit_sum   = a_q[cnt_q] ^ b_q[cnt_q] ^ c_q;
   assign bit_carry = (a_q[cnt_q] & b_q[cnt_q]) | (c_q & (a_q[cnt_q] ^ b_q[cnt_q]));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      carry_d = carry_q;
      id_d    = id_q;
      prio_d  = prio_q;
`ifdef SERIAL_ADD_SUB_EN
      sub_d   = sub_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (|ready) begin
               a_d     = op_a;
               b_d     = op_b;
               c_d     = 1'b0;
               cnt_d   = '0;
               id_d    = grant;
               prio_d  = ~grant;
               state_d = RUN;
`ifdef SERIAL_ADD_SUB_EN
               // Subtract as A + ~B + 1: invert B and preload the carry.
               sub_d = bus.req_sub[grant];
               if (bus.req_sub[grant]) begin
                  b_d = ~op_b;
                  c_d = 1'b1;
               end
`endif
            end
         end
         RUN: begin
            sum_d[cnt_q] = bit_sum;
            c_d          = bit_carry;
            cnt_d        = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               carry_d = bit_carry;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         carry_q <= 1'b0;
         id_q    <= 1'b0;
         prio_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
         sub_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         carry_q <= carry_d;
         id_q    <= id_d;
         prio_q  <= prio_d;
`ifdef SERIAL_ADD_SUB_EN
         sub_q   <= sub_d;
`endif
      end
   end

   assign bus.req_ready = ready;
   assign bus.rsp_valid = (state_q == DONE);
   assign bus.rsp_id    = id_q;
   assign bus.rsp_sum   = sum_q;
   assign bus.rsp_carry = carry_q;
`ifdef SERIAL_ADD_SUB_EN
   assign bus.rsp_sub   = sub_q;
`endif
   assign busy          = (state_q != IDLE);

endmodule
